// File: rtl/cpu_control_fsm.sv
// rtl/cpu_control_fsm.sv - instruction register, decoder and control sequencer for the datapath
//
// Latches a 16-bit instruction and steps through one micro-operation per clock. Each step
// drives the datapath register-file selects, pipeline register loads and ALU/shifter controls.
// Every output is a function of state and IR only, and is held in a register.
//
// Ports:
//   clk, reset_n        clock; synchronous active-low reset
//   in, load, s         instruction word, IR capture strobe, start strobe (both honoured in WAIT)
//   w, illegal          idle/ready flag, one-cycle unsupported-opcode pulse
//   readnum, writenum   register file read/write selects
//   write, vsel         register file write enable, one-hot writeback select
//   loada, loadb, loadc, loads   A/B/C/status register loads
//   asel, bsel, shift, ALUop     ALU operand selects, shifter op, ALU op
//   sximm8, sximm5      sign-extended immediates, combinational from IR
module cpu_control_fsm #(
  parameter bit STATUS_ON_ALL = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic        illegal,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [3:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic        loadc,
  output logic        loads,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG
  } state_t;

  typedef enum logic [1:0] {C_MOV_IMM, C_ALU_AB, C_ALU_B, C_BAD} iclass_t;

  typedef struct packed {
    logic       w;
    logic       illegal;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic [3:0] vsel;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic [1:0] shift;
    logic [1:0] aluop;
    logic       loadc;
    logic       loads;
  } ctl_t;

  state_t      state, state_nx;
  logic [15:0] ir, ir_nx;
  ctl_t        ctl_q, ctl_nx;

  // ALU_AB reads Rn then Rm; ALU_B (MOV reg, MVN) needs only Rm.
  function automatic iclass_t classify(input logic [15:0] i);
    case ({i[15:13], i[12:11]})
      5'b110_10:                     classify = C_MOV_IMM;
      5'b101_00, 5'b101_01, 5'b101_10: classify = C_ALU_AB;
      5'b110_00, 5'b101_11:          classify = C_ALU_B;
      default:                       classify = C_BAD;
    endcase
  endfunction

  always_comb begin
    state_nx = state;
    ir_nx    = ir;
    case (state)
      S_WAIT: begin
        if (load) ir_nx = in;
        if (s) state_nx = S_DECODE;
      end
      S_DECODE: begin
        case (classify(ir))
          C_MOV_IMM: state_nx = S_WRITE_IMM;
          C_ALU_AB:  state_nx = S_GET_A;
          C_ALU_B:   state_nx = S_GET_B;
          default:   state_nx = S_WAIT;
        endcase
      end
      S_WRITE_IMM: state_nx = S_WAIT;
      S_GET_A:     state_nx = S_GET_B;
      S_GET_B:     state_nx = S_ALU;
      S_ALU:       state_nx = (ir[15:11] == 5'b101_01) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_nx = S_WAIT;
      default:     state_nx = S_WAIT;
    endcase
  end

  // Outputs are precomputed for the state being entered so the registered copy is
  // exactly the Moore output of that state with its IR.
  always_comb begin
    ctl_nx = '0;
    case (state_nx)
      S_WAIT:      ctl_nx.w = 1'b1;
      S_DECODE:    ctl_nx.illegal = (classify(ir_nx) == C_BAD);
      S_WRITE_IMM: begin
        ctl_nx.writenum = ir_nx[10:8];
        ctl_nx.vsel     = 4'b0100;
        ctl_nx.write    = 1'b1;
      end
      S_GET_A: begin
        ctl_nx.readnum = ir_nx[10:8];
        ctl_nx.loada   = 1'b1;
      end
      S_GET_B: begin
        ctl_nx.readnum = ir_nx[2:0];
        ctl_nx.loadb   = 1'b1;
      end
      S_ALU: begin
        ctl_nx.shift = ir_nx[4:3];
        ctl_nx.loadc = 1'b1;
        ctl_nx.asel  = (ir_nx[15:13] == 3'b110);
        ctl_nx.aluop = (ir_nx[15:13] == 3'b101) ? ir_nx[12:11] : 2'b00;
        ctl_nx.loads = (ir_nx[15:11] == 5'b101_01) || STATUS_ON_ALL;
      end
      S_WRITE_REG: begin
        ctl_nx.writenum = ir_nx[7:5];
        ctl_nx.vsel     = 4'b0001;
        ctl_nx.write    = 1'b1;
      end
      default: ctl_nx = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_WAIT;
      ir      <= 16'h0000;
      ctl_q   <= '0;
      ctl_q.w <= 1'b1;
    end else begin
      state <= state_nx;
      ir    <= ir_nx;
      ctl_q <= ctl_nx;
    end
  end

  assign w        = ctl_q.w;
  assign illegal  = ctl_q.illegal;
  assign readnum  = ctl_q.readnum;
  assign writenum = ctl_q.writenum;
  assign write    = ctl_q.write;
  assign vsel     = ctl_q.vsel;
  assign loada    = ctl_q.loada;
  assign loadb    = ctl_q.loadb;
  assign asel     = ctl_q.asel;
  assign bsel     = ctl_q.bsel;
  assign shift    = ctl_q.shift;
  assign ALUop    = ctl_q.aluop;
  assign loadc    = ctl_q.loadc;
  assign loads    = ctl_q.loads;

  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

endmodule
